riscv_axi_arbiter: RTL and testbench



---
 rtl/riscv_axi_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_riscv_axi_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_axi_arbiter.sv
// Two-master to one-slave AXI4 arbiter: icache (m0) and dcache (m1) share one
// external AXI4 port. Read and write directions arbitrate independently, each
// with one outstanding transaction and a registered grant that steers responses.
module riscv_axi_arbiter #(
  parameter int unsigned RR_ENABLE = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  // master 0 (icache)
  input  logic        m0_awvalid_i,
  input  logic [31:0] m0_awaddr_i,
  input  logic [3:0]  m0_awid_i,
  input  logic [7:0]  m0_awlen_i,
  input  logic [1:0]  m0_awburst_i,
  input  logic        m0_wvalid_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_wstrb_i,
  input  logic        m0_wlast_i,
  input  logic        m0_bready_i,
  input  logic        m0_rready_i,
  input  logic        m0_arvalid_i,
  input  logic [31:0] m0_araddr_i,
  input  logic [3:0]  m0_arid_i,
  input  logic [7:0]  m0_arlen_i,
  input  logic [1:0]  m0_arburst_i,
  output logic        m0_awready_o,
  output logic        m0_wready_o,
  output logic        m0_arready_o,
  output logic        m0_bvalid_o,
  output logic [1:0]  m0_bresp_o,
  output logic [3:0]  m0_bid_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic [1:0]  m0_rresp_o,
  output logic [3:0]  m0_rid_o,
  output logic        m0_rlast_o,
  // master 1 (dcache)
  input  logic        m1_awvalid_i,
  input  logic [31:0] m1_awaddr_i,
  input  logic [3:0]  m1_awid_i,
  input  logic [7:0]  m1_awlen_i,
  input  logic [1:0]  m1_awburst_i,
  input  logic        m1_wvalid_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_wstrb_i,
  input  logic        m1_wlast_i,
  input  logic        m1_bready_i,
  input  logic        m1_rready_i,
  input  logic        m1_arvalid_i,
  input  logic [31:0] m1_araddr_i,
  input  logic [3:0]  m1_arid_i,
  input  logic [7:0]  m1_arlen_i,
  input  logic [1:0]  m1_arburst_i,
  output logic        m1_awready_o,
  output logic        m1_wready_o,
  output logic        m1_arready_o,
  output logic        m1_bvalid_o,
  output logic [1:0]  m1_bresp_o,
  output logic [3:0]  m1_bid_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic [1:0]  m1_rresp_o,
  output logic [3:0]  m1_rid_o,
  output logic        m1_rlast_o,
  // slave side
  output logic        axi_awvalid_o,
  output logic [31:0] axi_awaddr_o,
  output logic [3:0]  axi_awid_o,
  output logic [7:0]  axi_awlen_o,
  output logic [1:0]  axi_awburst_o,
  output logic        axi_wvalid_o,
  output logic [31:0] axi_wdata_o,
  output logic [3:0]  axi_wstrb_o,
  output logic        axi_wlast_o,
  output logic        axi_arvalid_o,
  output logic [31:0] axi_araddr_o,
  output logic [3:0]  axi_arid_o,
  output logic [7:0]  axi_arlen_o,
  output logic [1:0]  axi_arburst_o,
  output logic        axi_bready_o,
  output logic        axi_rready_o,
  input  logic        axi_awready_i,
  input  logic        axi_wready_i,
  input  logic        axi_arready_i,
  input  logic        axi_bvalid_i,
  input  logic [1:0]  axi_bresp_i,
  input  logic [3:0]  axi_bid_i,
  input  logic        axi_rvalid_i,
  input  logic [31:0] axi_rdata_i,
  input  logic [1:0]  axi_rresp_i,
  input  logic [3:0]  axi_rid_i,
  input  logic        axi_rlast_i
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wr_state_e;

  rd_state_e rd_state_q, rd_state_d;
  wr_state_e wr_state_q, wr_state_d;
  logic      rd_grant_q, rd_grant_d, rd_last_q, rd_last_d;
  logic      wr_grant_q, wr_grant_d, wr_last_q, wr_last_d;
  logic      aw_done_q, aw_done_d, w_done_q, w_done_d;

  // Winner for a new grant; round-robin favours the master not served last.
  function automatic logic pick(input logic req0, input logic req1, input logic last);
    if (RR_ENABLE == 0) return req1;
    if (req0 && req1)   return ~last;
    return req1;
  endfunction

  // Phase decodes, gated by grant, steer every routed signal.
  logic rd_addr, rd_data, wr_xfer, wr_resp;
  logic ar_hs, r_last_hs, aw_hs, w_last_hs, b_hs;
  assign rd_addr = (rd_state_q == R_ADDR);
  assign rd_data = (rd_state_q == R_DATA);
  assign wr_xfer = (wr_state_q == W_XFER);
  assign wr_resp = (wr_state_q == W_RESP);

  // Read address and data routing.
  assign axi_arvalid_o = rd_addr & (rd_grant_q ? m1_arvalid_i : m0_arvalid_i);
  assign axi_araddr_o  = rd_addr ? (rd_grant_q ? m1_araddr_i  : m0_araddr_i)  : '0;
  assign axi_arid_o    = rd_addr ? (rd_grant_q ? m1_arid_i    : m0_arid_i)    : '0;
  assign axi_arlen_o   = rd_addr ? (rd_grant_q ? m1_arlen_i   : m0_arlen_i)   : '0;
  assign axi_arburst_o = rd_addr ? (rd_grant_q ? m1_arburst_i : m0_arburst_i) : '0;
  assign m0_arready_o  = rd_addr & ~rd_grant_q & axi_arready_i;
  assign m1_arready_o  = rd_addr &  rd_grant_q & axi_arready_i;
  assign axi_rready_o  = rd_data & (rd_grant_q ? m1_rready_i : m0_rready_i);
  assign m0_rvalid_o   = rd_data & ~rd_grant_q & axi_rvalid_i;
  assign m0_rdata_o    = (rd_data & ~rd_grant_q) ? axi_rdata_i : '0;
  assign m0_rresp_o    = (rd_data & ~rd_grant_q) ? axi_rresp_i : '0;
  assign m0_rid_o      = (rd_data & ~rd_grant_q) ? axi_rid_i   : '0;
  assign m0_rlast_o    = rd_data & ~rd_grant_q & axi_rlast_i;
  assign m1_rvalid_o   = rd_data &  rd_grant_q & axi_rvalid_i;
  assign m1_rdata_o    = (rd_data & rd_grant_q) ? axi_rdata_i : '0;
  assign m1_rresp_o    = (rd_data & rd_grant_q) ? axi_rresp_i : '0;
  assign m1_rid_o      = (rd_data & rd_grant_q) ? axi_rid_i   : '0;
  assign m1_rlast_o    = rd_data & rd_grant_q & axi_rlast_i;

  // Write address/data routing; each channel is masked once it has completed.
  assign axi_awvalid_o = wr_xfer & ~aw_done_q & (wr_grant_q ? m1_awvalid_i : m0_awvalid_i);
  assign axi_awaddr_o  = wr_xfer ? (wr_grant_q ? m1_awaddr_i  : m0_awaddr_i)  : '0;
  assign axi_awid_o    = wr_xfer ? (wr_grant_q ? m1_awid_i    : m0_awid_i)    : '0;
  assign axi_awlen_o   = wr_xfer ? (wr_grant_q ? m1_awlen_i   : m0_awlen_i)   : '0;
  assign axi_awburst_o = wr_xfer ? (wr_grant_q ? m1_awburst_i : m0_awburst_i) : '0;
  assign axi_wvalid_o  = wr_xfer & ~w_done_q & (wr_grant_q ? m1_wvalid_i : m0_wvalid_i);
  assign axi_wdata_o   = wr_xfer ? (wr_grant_q ? m1_wdata_i : m0_wdata_i) : '0;
  assign axi_wstrb_o   = wr_xfer ? (wr_grant_q ? m1_wstrb_i : m0_wstrb_i) : '0;
  assign axi_wlast_o   = wr_xfer & (wr_grant_q ? m1_wlast_i : m0_wlast_i);
  assign m0_awready_o  = wr_xfer & ~aw_done_q & ~wr_grant_q & axi_awready_i;
  assign m1_awready_o  = wr_xfer & ~aw_done_q &  wr_grant_q & axi_awready_i;
  assign m0_wready_o   = wr_xfer & ~w_done_q  & ~wr_grant_q & axi_wready_i;
  assign m1_wready_o   = wr_xfer & ~w_done_q  &  wr_grant_q & axi_wready_i;
  assign axi_bready_o  = wr_resp & (wr_grant_q ? m1_bready_i : m0_bready_i);
  assign m0_bvalid_o   = wr_resp & ~wr_grant_q & axi_bvalid_i;
  assign m0_bresp_o    = (wr_resp & ~wr_grant_q) ? axi_bresp_i : '0;
  assign m0_bid_o      = (wr_resp & ~wr_grant_q) ? axi_bid_i   : '0;
  assign m1_bvalid_o   = wr_resp & wr_grant_q & axi_bvalid_i;
  assign m1_bresp_o    = (wr_resp & wr_grant_q) ? axi_bresp_i : '0;
  assign m1_bid_o      = (wr_resp & wr_grant_q) ? axi_bid_i   : '0;

  assign ar_hs     = axi_arvalid_o & axi_arready_i;
  assign r_last_hs = rd_data & axi_rvalid_i & axi_rready_o & axi_rlast_i;
  assign aw_hs     = axi_awvalid_o & axi_awready_i;
  assign w_last_hs = axi_wvalid_o & axi_wready_i & axi_wlast_o;
  assign b_hs      = wr_resp & axi_bvalid_i & axi_bready_o;

  // Read FSM next state: grant on request, advance on AR and final R beat.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    rd_state_d = rd_state_q;
    rd_grant_d = rd_grant_q;
    rd_last_d  = rd_last_q;
    case (rd_state_q)
      R_IDLE: if (m0_arvalid_i || m1_arvalid_i) begin
        rd_grant_d = pick(m0_arvalid_i, m1_arvalid_i, rd_last_q);
        rd_state_d = R_ADDR;
      end
      R_ADDR: if (ar_hs) rd_state_d = R_DATA;
      R_DATA: if (r_last_hs) begin
        rd_last_d  = rd_grant_q;
        rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Write FSM next state: AW and W complete independently, then wait for B.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_grant_d = wr_grant_q;
    wr_last_d  = wr_last_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    case (wr_state_q)
      W_IDLE: if (m0_awvalid_i || m0_wvalid_i || m1_awvalid_i || m1_wvalid_i) begin
        wr_grant_d = pick(m0_awvalid_i | m0_wvalid_i, m1_awvalid_i | m1_wvalid_i, wr_last_q);
        wr_state_d = W_XFER;
      end
      W_XFER: begin
        if (aw_hs)     aw_done_d = 1'b1;
        if (w_last_hs) w_done_d  = 1'b1;
        if ((aw_done_q | aw_hs) && (w_done_q | w_last_hs)) wr_state_d = W_RESP;
      end
      W_RESP: if (b_hs) begin
        wr_last_d  = wr_grant_q;
        aw_done_d  = 1'b0;
        w_done_d   = 1'b0;
        wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // State, grant, pointer and flag registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n_i) begin
      rd_state_q <= R_IDLE;
      rd_grant_q <= 1'b0;
      rd_last_q  <= 1'b1;
      wr_state_q <= W_IDLE;
      wr_grant_q <= 1'b0;
      wr_last_q  <= 1'b1;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_grant_q <= rd_grant_d;
      rd_last_q  <= rd_last_d;
      wr_state_q <= wr_state_d;
      wr_grant_q <= wr_grant_d;
      wr_last_q  <= wr_last_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

endmodule

// File: tb/tb_riscv_axi_arbiter.sv
// Directed bench for riscv_axi_arbiter: a round-robin instance plus a
// fixed-priority instance sharing the same stimulus.
module tb_riscv_axi_arbiter;

  logic clk_i = 1'b0;
  logic rst_n_i;
  always #5 clk_i = ~clk_i;

  logic        m0_awvalid_i, m1_awvalid_i, m0_wvalid_i, m1_wvalid_i, m0_wlast_i, m1_wlast_i;
  logic [31:0] m0_awaddr_i, m1_awaddr_i, m0_wdata_i, m1_wdata_i, m0_araddr_i, m1_araddr_i;
  logic [3:0]  m0_awid_i, m1_awid_i, m0_wstrb_i, m1_wstrb_i, m0_arid_i, m1_arid_i;
  logic [7:0]  m0_awlen_i, m1_awlen_i, m0_arlen_i, m1_arlen_i;
  logic [1:0]  m0_awburst_i, m1_awburst_i, m0_arburst_i, m1_arburst_i;
  logic        m0_bready_i, m1_bready_i, m0_rready_i, m1_rready_i, m0_arvalid_i, m1_arvalid_i;
  logic        axi_awready_i, axi_wready_i, axi_arready_i, axi_bvalid_i, axi_rvalid_i, axi_rlast_i;
  logic [1:0]  axi_bresp_i, axi_rresp_i;
  logic [3:0]  axi_bid_i, axi_rid_i;
  logic [31:0] axi_rdata_i;

  // round-robin instance outputs
  logic        m0_awready_o, m0_wready_o, m0_arready_o, m0_bvalid_o, m0_rvalid_o, m0_rlast_o;
  logic        m1_awready_o, m1_wready_o, m1_arready_o, m1_bvalid_o, m1_rvalid_o, m1_rlast_o;
  logic [1:0]  m0_bresp_o, m1_bresp_o, m0_rresp_o, m1_rresp_o;
  logic [3:0]  m0_bid_o, m1_bid_o, m0_rid_o, m1_rid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        axi_awvalid_o, axi_wvalid_o, axi_wlast_o, axi_arvalid_o, axi_bready_o, axi_rready_o;
  logic [31:0] axi_awaddr_o, axi_wdata_o, axi_araddr_o;
  logic [3:0]  axi_awid_o, axi_wstrb_o, axi_arid_o;
  logic [7:0]  axi_awlen_o, axi_arlen_o;
  logic [1:0]  axi_awburst_o, axi_arburst_o;

  // fixed-priority instance outputs
  logic        f_m0_awready, f_m0_wready, f_m0_arready, f_m0_bvalid, f_m0_rvalid, f_m0_rlast;
  logic        f_m1_awready, f_m1_wready, f_m1_arready, f_m1_bvalid, f_m1_rvalid, f_m1_rlast;
  logic [1:0]  f_m0_bresp, f_m1_bresp, f_m0_rresp, f_m1_rresp;
  logic [3:0]  f_m0_bid, f_m1_bid, f_m0_rid, f_m1_rid;
  logic [31:0] f_m0_rdata, f_m1_rdata;
  logic        f_awvalid, f_wvalid, f_wlast, f_arvalid, f_bready, f_rready;
  logic [31:0] f_awaddr, f_wdata, f_araddr;
  logic [3:0]  f_awid, f_wstrb, f_arid;
  logic [7:0]  f_awlen, f_arlen;
  logic [1:0]  f_awburst, f_arburst;

  riscv_axi_arbiter #(.RR_ENABLE(1)) u_dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m0_awvalid_i(m0_awvalid_i), .m0_awaddr_i(m0_awaddr_i), .m0_awid_i(m0_awid_i),
    .m0_awlen_i(m0_awlen_i), .m0_awburst_i(m0_awburst_i), .m0_wvalid_i(m0_wvalid_i),
    .m0_wdata_i(m0_wdata_i), .m0_wstrb_i(m0_wstrb_i), .m0_wlast_i(m0_wlast_i),
    .m0_bready_i(m0_bready_i), .m0_rready_i(m0_rready_i), .m0_arvalid_i(m0_arvalid_i),
    .m0_araddr_i(m0_araddr_i), .m0_arid_i(m0_arid_i), .m0_arlen_i(m0_arlen_i),
    .m0_arburst_i(m0_arburst_i),
    .m0_awready_o(m0_awready_o), .m0_wready_o(m0_wready_o), .m0_arready_o(m0_arready_o),
    .m0_bvalid_o(m0_bvalid_o), .m0_bresp_o(m0_bresp_o), .m0_bid_o(m0_bid_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_rresp_o(m0_rresp_o),
    .m0_rid_o(m0_rid_o), .m0_rlast_o(m0_rlast_o),
    .m1_awvalid_i(m1_awvalid_i), .m1_awaddr_i(m1_awaddr_i), .m1_awid_i(m1_awid_i),
    .m1_awlen_i(m1_awlen_i), .m1_awburst_i(m1_awburst_i), .m1_wvalid_i(m1_wvalid_i),
    .m1_wdata_i(m1_wdata_i), .m1_wstrb_i(m1_wstrb_i), .m1_wlast_i(m1_wlast_i),
    .m1_bready_i(m1_bready_i), .m1_rready_i(m1_rready_i), .m1_arvalid_i(m1_arvalid_i),
    .m1_araddr_i(m1_araddr_i), .m1_arid_i(m1_arid_i), .m1_arlen_i(m1_arlen_i),
    .m1_arburst_i(m1_arburst_i),
    .m1_awready_o(m1_awready_o), .m1_wready_o(m1_wready_o), .m1_arready_o(m1_arready_o),
    .m1_bvalid_o(m1_bvalid_o), .m1_bresp_o(m1_bresp_o), .m1_bid_o(m1_bid_o),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_rresp_o(m1_rresp_o),
    .m1_rid_o(m1_rid_o), .m1_rlast_o(m1_rlast_o),
    .axi_awvalid_o(axi_awvalid_o), .axi_awaddr_o(axi_awaddr_o), .axi_awid_o(axi_awid_o),
    .axi_awlen_o(axi_awlen_o), .axi_awburst_o(axi_awburst_o), .axi_wvalid_o(axi_wvalid_o),
    .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o), .axi_wlast_o(axi_wlast_o),
    .axi_arvalid_o(axi_arvalid_o), .axi_araddr_o(axi_araddr_o), .axi_arid_o(axi_arid_o),
    .axi_arlen_o(axi_arlen_o), .axi_arburst_o(axi_arburst_o), .axi_bready_o(axi_bready_o),
    .axi_rready_o(axi_rready_o),
    .axi_awready_i(axi_awready_i), .axi_wready_i(axi_wready_i), .axi_arready_i(axi_arready_i),
    .axi_bvalid_i(axi_bvalid_i), .axi_bresp_i(axi_bresp_i), .axi_bid_i(axi_bid_i),
    .axi_rvalid_i(axi_rvalid_i), .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
    .axi_rid_i(axi_rid_i), .axi_rlast_i(axi_rlast_i)
  );

  riscv_axi_arbiter #(.RR_ENABLE(0)) u_fix (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m0_awvalid_i(m0_awvalid_i), .m0_awaddr_i(m0_awaddr_i), .m0_awid_i(m0_awid_i),
    .m0_awlen_i(m0_awlen_i), .m0_awburst_i(m0_awburst_i), .m0_wvalid_i(m0_wvalid_i),
    .m0_wdata_i(m0_wdata_i), .m0_wstrb_i(m0_wstrb_i), .m0_wlast_i(m0_wlast_i),
    .m0_bready_i(m0_bready_i), .m0_rready_i(m0_rready_i), .m0_arvalid_i(m0_arvalid_i),
    .m0_araddr_i(m0_araddr_i), .m0_arid_i(m0_arid_i), .m0_arlen_i(m0_arlen_i),
    .m0_arburst_i(m0_arburst_i),
    .m0_awready_o(f_m0_awready), .m0_wready_o(f_m0_wready), .m0_arready_o(f_m0_arready),
    .m0_bvalid_o(f_m0_bvalid), .m0_bresp_o(f_m0_bresp), .m0_bid_o(f_m0_bid),
    .m0_rvalid_o(f_m0_rvalid), .m0_rdata_o(f_m0_rdata), .m0_rresp_o(f_m0_rresp),
    .m0_rid_o(f_m0_rid), .m0_rlast_o(f_m0_rlast),
    .m1_awvalid_i(m1_awvalid_i), .m1_awaddr_i(m1_awaddr_i), .m1_awid_i(m1_awid_i),
    .m1_awlen_i(m1_awlen_i), .m1_awburst_i(m1_awburst_i), .m1_wvalid_i(m1_wvalid_i),
    .m1_wdata_i(m1_wdata_i), .m1_wstrb_i(m1_wstrb_i), .m1_wlast_i(m1_wlast_i),
    .m1_bready_i(m1_bready_i), .m1_rready_i(m1_rready_i), .m1_arvalid_i(m1_arvalid_i),
    .m1_araddr_i(m1_araddr_i), .m1_arid_i(m1_arid_i), .m1_arlen_i(m1_arlen_i),
    .m1_arburst_i(m1_arburst_i),
    .m1_awready_o(f_m1_awready), .m1_wready_o(f_m1_wready), .m1_arready_o(f_m1_arready),
    .m1_bvalid_o(f_m1_bvalid), .m1_bresp_o(f_m1_bresp), .m1_bid_o(f_m1_bid),
    .m1_rvalid_o(f_m1_rvalid), .m1_rdata_o(f_m1_rdata), .m1_rresp_o(f_m1_rresp),
    .m1_rid_o(f_m1_rid), .m1_rlast_o(f_m1_rlast),
    .axi_awvalid_o(f_awvalid), .axi_awaddr_o(f_awaddr), .axi_awid_o(f_awid),
    .axi_awlen_o(f_awlen), .axi_awburst_o(f_awburst), .axi_wvalid_o(f_wvalid),
    .axi_wdata_o(f_wdata), .axi_wstrb_o(f_wstrb), .axi_wlast_o(f_wlast),
    .axi_arvalid_o(f_arvalid), .axi_araddr_o(f_araddr), .axi_arid_o(f_arid),
    .axi_arlen_o(f_arlen), .axi_arburst_o(f_arburst), .axi_bready_o(f_bready),
    .axi_rready_o(f_rready),
    .axi_awready_i(axi_awready_i), .axi_wready_i(axi_wready_i), .axi_arready_i(axi_arready_i),
    .axi_bvalid_i(axi_bvalid_i), .axi_bresp_i(axi_bresp_i), .axi_bid_i(axi_bid_i),
    .axi_rvalid_i(axi_rvalid_i), .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
    .axi_rid_i(axi_rid_i), .axi_rlast_i(axi_rlast_i)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    {m0_awvalid_i, m1_awvalid_i, m0_wvalid_i, m1_wvalid_i, m0_wlast_i, m1_wlast_i} = '0;
    {m0_awaddr_i, m1_awaddr_i, m0_wdata_i, m1_wdata_i, m0_araddr_i, m1_araddr_i} = '0;
    {m0_awid_i, m1_awid_i, m0_wstrb_i, m1_wstrb_i, m0_arid_i, m1_arid_i} = '0;
    {m0_awlen_i, m1_awlen_i, m0_arlen_i, m1_arlen_i} = '0;
    {m0_awburst_i, m1_awburst_i, m0_arburst_i, m1_arburst_i} = '0;
    {m0_arvalid_i, m1_arvalid_i} = '0;
    {m0_bready_i, m1_bready_i, m0_rready_i, m1_rready_i} = '1;
    {axi_awready_i, axi_wready_i, axi_arready_i} = '1;
    {axi_bvalid_i, axi_rvalid_i, axi_rlast_i, axi_bresp_i, axi_rresp_i} = '0;
    {axi_bid_i, axi_rid_i, axi_rdata_i} = '0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst_n_i = 1'b0;
    tick();
    tick();
    rst_n_i = 1'b1;
  endtask

  // Called in R_ADDR for master m: checks AR routing, then plays a burst of beats.
  task automatic rd_burst(input int m, input logic [31:0] addr, input logic [3:0] id,
                          input int beats);
    check("ar_valid", axi_arvalid_o, 1);
    check("ar_addr", axi_araddr_o, addr);
    check("ar_id", axi_arid_o, id);
    check("ar_ready_win", (m == 1) ? m1_arready_o : m0_arready_o, 1);
    check("ar_ready_lose", (m == 1) ? m0_arready_o : m1_arready_o, 0);
    tick();
    if (m == 1) m1_arvalid_i = 1'b0; else m0_arvalid_i = 1'b0;
    for (int i = 0; i < beats; i++) begin
      axi_rvalid_i = 1'b1;
      axi_rdata_i  = 32'hA000_0000 + i;
      axi_rid_i    = id;
      axi_rlast_i  = (i == beats - 1);
      #1;
      check("r_valid_win", (m == 1) ? m1_rvalid_o : m0_rvalid_o, 1);
      check("r_data_win", (m == 1) ? m1_rdata_o : m0_rdata_o, 32'hA000_0000 + i);
      check("r_id_win", (m == 1) ? m1_rid_o : m0_rid_o, id);
      check("r_last_win", (m == 1) ? m1_rlast_o : m0_rlast_o, (i == beats - 1));
      check("r_valid_lose", (m == 1) ? m0_rvalid_o : m1_rvalid_o, 0);
      check("r_ready", axi_rready_o, 1);
      tick();
    end
    axi_rvalid_i = 1'b0;
    axi_rlast_i  = 1'b0;
  endtask

  initial begin
    // Reset with active stimulus: everything must stay quiet.
    clear_inputs();
    rst_n_i      = 1'b0;
    m0_arvalid_i = 1'b1;
    m1_awvalid_i = 1'b1;
    axi_rvalid_i = 1'b1;
    axi_bvalid_i = 1'b1;
    tick();
    tick();
    check("rst_arvalid", axi_arvalid_o, 0);
    check("rst_araddr", axi_araddr_o, 0);
    check("rst_awvalid", axi_awvalid_o, 0);
    check("rst_m0_rvalid", m0_rvalid_o, 0);
    check("rst_m1_bvalid", m1_bvalid_o, 0);
    check("rst_m0_arready", m0_arready_o, 0);

    // Single read, m0, len 7; m1 not ready so rready routing is visible.
    reset_dut();
    m1_rready_i  = 1'b0;
    m0_arvalid_i = 1'b1;
    m0_araddr_i  = 32'h8000_0000;
    m0_arid_i    = 4'h5;
    m0_arlen_i   = 8'd7;
    m0_arburst_i = 2'b01;
    #1;
    check("lat_cycle_t", axi_arvalid_o, 0);
    tick();
    check("ar_len", axi_arlen_o, 7);
    check("ar_burst", axi_arburst_o, 1);
    rd_burst(0, 32'h8000_0000, 4'h5, 8);
    check("rd_idle_arvalid", axi_arvalid_o, 0);
    check("rd_idle_rready", axi_rready_o, 0);

    // Simultaneous AR: round-robin m0, m1, m0; fixed priority picks m1.
    reset_dut();
    m0_arvalid_i = 1'b1; m0_araddr_i = 32'h0000_1000; m0_arid_i = 4'h1;
    m1_arvalid_i = 1'b1; m1_araddr_i = 32'h0000_2000; m1_arid_i = 4'h2;
    tick();
    check("fix_araddr", f_araddr, 32'h0000_2000);
    check("fix_m1_arready", f_m1_arready, 1);
    check("fix_m0_arready", f_m0_arready, 0);
    rd_burst(0, 32'h0000_1000, 4'h1, 1);
    m0_arvalid_i = 1'b1;
    tick();
    check("fix_again_m1", f_araddr, 32'h0000_2000);
    rd_burst(1, 32'h0000_2000, 4'h2, 2);
    m1_arvalid_i = 1'b1;
    tick();
    rd_burst(0, 32'h0000_1000, 4'h1, 1);
    m1_arvalid_i = 1'b0;

    // Write with W before AW: awready held low 3 cycles.
    reset_dut();
    axi_awready_i = 1'b0;
    m1_awvalid_i = 1'b1; m1_awaddr_i = 32'h2000_0040; m1_awid_i = 4'h3;
    m1_wvalid_i  = 1'b1; m1_wdata_i  = 32'hDEAD_BEEF; m1_wstrb_i = 4'hF; m1_wlast_i = 1'b1;
    tick();
    check("w_first_valid", axi_wvalid_o, 1);
    check("w_first_data", axi_wdata_o, 32'hDEAD_BEEF);
    check("w_first_m1_wready", m1_wready_o, 1);
    check("w_first_m0_wready", m0_wready_o, 0);
    check("w_first_m1_awready", m1_awready_o, 0);
    tick();
    m1_wvalid_i = 1'b0;
    #1;
    check("w_done_wvalid", axi_wvalid_o, 0);
    check("w_done_awvalid", axi_awvalid_o, 1);
    tick();
    axi_awready_i = 1'b1;
    #1;
    check("aw_late_ready", m1_awready_o, 1);
    check("aw_late_addr", axi_awaddr_o, 32'h2000_0040);
    check("aw_late_id", axi_awid_o, 4'h3);
    tick();
    m1_awvalid_i = 1'b0;
    axi_bvalid_i = 1'b1; axi_bresp_i = 2'b00; axi_bid_i = 4'h3;
    #1;
    check("b_m1_valid", m1_bvalid_o, 1);
    check("b_m1_resp", m1_bresp_o, 0);
    check("b_m1_id", m1_bid_o, 4'h3);
    check("b_m0_valid", m0_bvalid_o, 0);
    check("b_bready", axi_bready_o, 1);
    tick();
    axi_bvalid_i = 1'b0;
    #1;
    check("b_idle_bready", axi_bready_o, 0);

    // Concurrent m0 read (rresp error on beat 3 of 4) with m1 write (DECERR).
    reset_dut();
    m0_arvalid_i = 1'b1; m0_araddr_i = 32'h8000_1000; m0_arid_i = 4'h2; m0_arlen_i = 8'd3;
    m1_awvalid_i = 1'b1; m1_awaddr_i = 32'h4000_0000; m1_awid_i = 4'h7;
    m1_wvalid_i  = 1'b1; m1_wdata_i  = 32'h1234_5678; m1_wstrb_i = 4'hF; m1_wlast_i = 1'b1;
    tick();
    check("cc_arvalid", axi_arvalid_o, 1);
    check("cc_araddr", axi_araddr_o, 32'h8000_1000);
    check("cc_awaddr", axi_awaddr_o, 32'h4000_0000);
    check("cc_wdata", axi_wdata_o, 32'h1234_5678);
    check("cc_m1_awready", m1_awready_o, 1);
    check("cc_m0_awready", m0_awready_o, 0);
    tick();
    m0_arvalid_i = 1'b0; m1_awvalid_i = 1'b0; m1_wvalid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      axi_rvalid_i = 1'b1;
      axi_rdata_i  = 32'hC000_0000 + i;
      axi_rid_i    = 4'h2;
      axi_rresp_i  = (i == 2) ? 2'b10 : 2'b00;
      axi_rlast_i  = (i == 3);
      axi_bvalid_i = (i == 0);
      axi_bresp_i  = 2'b11;
      axi_bid_i    = 4'h7;
      #1;
      check("cc_m0_rvalid", m0_rvalid_o, 1);
      check("cc_m0_rdata", m0_rdata_o, 32'hC000_0000 + i);
      check("cc_m0_rresp", m0_rresp_o, (i == 2) ? 2'b10 : 2'b00);
      check("cc_m1_rvalid", m1_rvalid_o, 0);
      check("cc_m0_bvalid", m0_bvalid_o, 0);
      if (i == 0) begin
        check("cc_m1_bvalid", m1_bvalid_o, 1);
        check("cc_m1_bresp", m1_bresp_o, 2'b11);
        check("cc_m1_bid", m1_bid_o, 4'h7);
      end else begin
        check("cc_wr_idle_bready", axi_bready_o, 0);
      end
      tick();
    end
    axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0; axi_rresp_i = 2'b00;
    #1;
    check("cc_rd_idle_rready", axi_rready_o, 0);

    // Reset mid-burst, then a tie arbitrates from the reset pointer (m0 wins).
    reset_dut();
    m0_arvalid_i = 1'b1; m0_araddr_i = 32'h8000_2000; m0_arid_i = 4'h4; m0_arlen_i = 8'd3;
    tick();
    tick();
    m0_arvalid_i = 1'b0;
    axi_rvalid_i = 1'b1; axi_rdata_i = 32'h5555_0000; axi_rid_i = 4'h4;
    #1;
    check("mid_rvalid_before", m0_rvalid_o, 1);
    tick();
    rst_n_i = 1'b0;
    tick();
    check("mid_rst_rvalid", m0_rvalid_o, 0);
    check("mid_rst_rdata", m0_rdata_o, 0);
    check("mid_rst_rready", axi_rready_o, 0);
    check("mid_rst_arvalid", axi_arvalid_o, 0);
    rst_n_i = 1'b1;
    axi_rvalid_i = 1'b0;
    m0_arvalid_i = 1'b1; m0_araddr_i = 32'h8000_3000; m0_arid_i = 4'h6;
    m1_arvalid_i = 1'b1; m1_araddr_i = 32'h9000_0000; m1_arid_i = 4'h9;
    tick();
    rd_burst(0, 32'h8000_3000, 4'h6, 1);
    m1_arvalid_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
